// File: rtl/aes_pkg.sv
// Shared types and sizing for the AES-128 key-schedule controller and its round-key store.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CAPTURE,
    READY
  } state_e;

  localparam int unsigned NUM_RK       = 11;
  localparam int unsigned RK_W         = 128;
  localparam int unsigned AES128_KEY_W = 128;

endpackage

// File: rtl/aes_rk_store.sv
// Round-key register file: synchronous write, registered read, async clear.
// The read register returns zero unless a read is strobed, so callers get a clean data bus.
module aes_rk_store
  import aes_pkg::*;
#(
  parameter int unsigned DEPTH  = NUM_RK,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = RK_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_i && (32'(wr_addr_i) < DEPTH)) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_en_i && (32'(rd_addr_i) < DEPTH)) begin
      rd_data_q <= mem_q[rd_addr_i];
    end else begin
      rd_data_q <= '0;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-schedule controller: accepts a key, pulses the expander load, captures
// round keys 0..10 into a local store and serves them through a 1-cycle read port.
module aes_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned NUM_RK = aes_pkg::NUM_RK,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [127:0]      key_in,
  input  logic              key_valid,
  output logic              key_ready,
  input  logic              flush,
  output logic              kexp_kld,
  output logic [255:0]      kexp_key,
  input  logic [31:0]       kexp_w0,
  input  logic [31:0]       kexp_w1,
  input  logic [31:0]       kexp_w2,
  input  logic [31:0]       kexp_w3,
  input  logic              rk_rd_en,
  input  logic [ADDR_W-1:0] rk_rd_addr,
  output logic [RK_W-1:0]   rk_rd_data,
  output logic              rk_rd_valid,
  output logic              rk_rd_err,
  output logic              keys_ready,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_RK - 1);

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       cnt_q, cnt_d;
  logic [AES128_KEY_W-1:0] key_q, key_d;
  logic                    rd_valid_q, rd_err_q;
  logic                    accept;
  logic                    rd_ok;
  logic                    store_wr;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    key_d     = key_q;
    key_ready = (state_q == IDLE) || (state_q == READY);
    // flush wins over a same-cycle request, so accept is masked here as well
    accept    = key_valid && key_ready && !flush;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE, READY: begin
          if (accept) begin
            state_d = LOAD;
            key_d   = key_in;
          end
        end
        LOAD: begin
          state_d = CAPTURE;
          cnt_d   = '0;
        end
        CAPTURE: begin
          if (cnt_q == LAST_IDX) begin
            state_d = READY;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign kexp_kld   = (state_q == LOAD);
  assign kexp_key   = {{(256 - AES128_KEY_W){1'b0}}, key_q};
  assign busy       = (state_q == LOAD) || (state_q == CAPTURE);
  assign keys_ready = (state_q == READY);

  // Reads see the store as it was before this edge, so a read in an accept cycle returns old keys
  assign rd_ok    = rk_rd_en && (state_q == READY) && (rk_rd_addr <= LAST_IDX);
  assign store_wr = (state_q == CAPTURE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      key_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      key_q      <= key_d;
      rd_valid_q <= rd_ok;
      rd_err_q   <= rk_rd_en && !rd_ok;
    end
  end

  aes_rk_store #(
    .DEPTH (NUM_RK),
    .ADDR_W(ADDR_W),
    .DATA_W(RK_W)
  ) u_store (
    .clk      (clk),
    .rst      (rst),
    .wr_en_i  (store_wr),
    .wr_addr_i(cnt_q),
    .wr_data_i({kexp_w0, kexp_w1, kexp_w2, kexp_w3}),
    .rd_en_i  (rd_ok),
    .rd_addr_i(rk_rd_addr),
    .rd_data_o(rk_rd_data)
  );

  assign rk_rd_valid = rd_valid_q;
  assign rk_rd_err   = rd_err_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench for aes_key_sched_ctrl with a behavioural AES-128 key expander on the w0..w3 side.
module tb_aes_key_sched_ctrl;

  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY2      = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY2_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] key_in;
  logic         key_valid, key_ready, flush;
  logic         kexp_kld;
  logic [255:0] kexp_key;
  logic [31:0]  kexp_w0, kexp_w1, kexp_w2, kexp_w3;
  logic         rk_rd_en;
  logic [3:0]   rk_rd_addr;
  logic [127:0] rk_rd_data;
  logic         rk_rd_valid, rk_rd_err, keys_ready, busy;

  int checks   = 0;
  int failures = 0;
  logic [127:0] exp_rk [11];

  always #5 clk = ~clk;

  aes_key_sched_ctrl #(.NUM_RK(11), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready),
    .flush(flush), .kexp_kld(kexp_kld), .kexp_key(kexp_key),
    .kexp_w0(kexp_w0), .kexp_w1(kexp_w1), .kexp_w2(kexp_w2), .kexp_w3(kexp_w3),
    .rk_rd_en(rk_rd_en), .rk_rd_addr(rk_rd_addr), .rk_rd_data(rk_rd_data),
    .rk_rd_valid(rk_rd_valid), .rk_rd_err(rk_rd_err), .keys_ready(keys_ready), .busy(busy));

  function automatic logic [7:0] sb(input logic [7:0] b);
    return SBOX[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [7:0] rcon_of(input int unsigned r);
    case (r)
      0: return 8'h01;  1: return 8'h02;  2: return 8'h04;  3: return 8'h08;
      4: return 8'h10;  5: return 8'h20;  6: return 8'h40;  7: return 8'h80;
      8: return 8'h1b;  9: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] next_rk(input logic [127:0] w, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = {w[23:0], w[31:24]};
    t  = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])} ^ {rc, 24'h0};
    n0 = w[127:96] ^ t;
    n1 = w[95:64] ^ n0;
    n2 = w[63:32] ^ n1;
    n3 = w[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Expander: loads on the kld edge, then advances one round per clock
  logic [127:0] ew = '0;
  int unsigned  eround = 0;
  always @(posedge clk) begin
    if (kexp_kld) begin
      ew     <= kexp_key[127:0];
      eround <= 0;
    end else begin
      ew     <= next_rk(ew, rcon_of(eround));
      eround <= eround + 1;
    end
  end
  assign {kexp_w0, kexp_w1, kexp_w2, kexp_w3} = ew;

  task automatic compute_rks(input logic [127:0] k);
    exp_rk[0] = k;
    for (int i = 1; i < 11; i++) exp_rk[i] = next_rk(exp_rk[i-1], rcon_of(i - 1));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [3:0] a);
    rk_rd_en   = 1'b1;
    rk_rd_addr = a;
    tick();
    rk_rd_en   = 1'b0;
  endtask

  task automatic accept_key(input logic [127:0] k);
    key_in    = k;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!keys_ready && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; key_in = '0; key_valid = 1'b0; flush = 1'b0; rk_rd_en = 1'b0; rk_rd_addr = '0;
    repeat (2) tick();
    checks++;
    if ({key_ready, kexp_kld, keys_ready, busy, rk_rd_valid, rk_rd_err} !== 6'b100000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=100000",
               {key_ready, kexp_kld, keys_ready, busy, rk_rd_valid, rk_rd_err});
    end
    checks++;
    if (kexp_key !== '0 || rk_rd_data !== '0) begin
      failures++; $display("FAIL reset_data kexp_key=%h rd_data=%h exp=0", kexp_key, rk_rd_data);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_read_before_load();
    do_read(4'd0);
    checks++;
    if ({rk_rd_err, rk_rd_valid} !== 2'b10 || rk_rd_data !== '0) begin
      failures++;
      $display("FAIL early_read err/valid=%b data=%h exp=10/0", {rk_rd_err, rk_rd_valid}, rk_rd_data);
    end
    tick();
    checks++;
    if (rk_rd_err !== 1'b0) begin failures++; $display("FAIL early_read_pulse err=%b exp=0", rk_rd_err); end
  endtask

  task automatic test_load_fips();
    int n;
    compute_rks(FIPS_KEY);
    checks++;
    if (key_ready !== 1'b1) begin failures++; $display("FAIL idle_key_ready got=%b exp=1", key_ready); end
    accept_key(FIPS_KEY);
    checks++;
    if ({kexp_kld, busy, key_ready} !== 3'b110 || kexp_key !== {128'h0, FIPS_KEY}) begin
      failures++;
      $display("FAIL load_cycle kld/busy/kr=%b key=%h", {kexp_kld, busy, key_ready}, kexp_key);
    end
    tick();
    checks++;
    if ({kexp_kld, busy} !== 2'b01) begin
      failures++; $display("FAIL capture_cycle kld/busy=%b exp=01", {kexp_kld, busy});
    end
    wait_ready(n);
    n++;
    checks++;
    if (n !== 12) begin failures++; $display("FAIL load_latency got=%0d exp=12", n); end
    checks++;
    if ({busy, key_ready} !== 2'b01) begin
      failures++; $display("FAIL ready_flags busy/kr=%b exp=01", {busy, key_ready});
    end
    for (int a = 0; a < 11; a++) begin
      do_read(4'(a));
      checks++;
      if ({rk_rd_valid, rk_rd_err} !== 2'b10 || rk_rd_data !== exp_rk[a]) begin
        failures++;
        $display("FAIL fips_rk%0d v/e=%b got=%h exp=%h", a, {rk_rd_valid, rk_rd_err}, rk_rd_data, exp_rk[a]);
      end
    end
    do_read(4'd0);
    checks++;
    if (rk_rd_data !== FIPS_KEY) begin
      failures++; $display("FAIL fips_rk0_const got=%h exp=%h", rk_rd_data, FIPS_KEY);
    end
    do_read(4'd10);
    checks++;
    if (rk_rd_data !== FIPS_RK10) begin
      failures++; $display("FAIL fips_rk10_const got=%h exp=%h", rk_rd_data, FIPS_RK10);
    end
  endtask

  task automatic test_bad_addr();
    logic [3:0] bad [2];
    bad[0] = 4'd11;
    bad[1] = 4'd15;
    for (int i = 0; i < 2; i++) begin
      do_read(bad[i]);
      checks++;
      if ({rk_rd_err, rk_rd_valid} !== 2'b10 || rk_rd_data !== '0) begin
        failures++;
        $display("FAIL bad_addr_%0d err/valid=%b data=%h exp=10/0", bad[i], {rk_rd_err, rk_rd_valid}, rk_rd_data);
      end
    end
    tick();
    checks++;
    if ({rk_rd_err, keys_ready} !== 2'b01) begin
      failures++; $display("FAIL bad_addr_after err/kr=%b exp=01", {rk_rd_err, keys_ready});
    end
  endtask

  task automatic test_back_to_back();
    int n;
    key_in = KEY2; key_valid = 1'b1; rk_rd_en = 1'b1; rk_rd_addr = 4'd10;
    tick();
    key_valid = 1'b0; rk_rd_en = 1'b0;
    checks++;
    if (rk_rd_valid !== 1'b1 || rk_rd_data !== FIPS_RK10) begin
      failures++; $display("FAIL b2b_old_read valid=%b got=%h exp=%h", rk_rd_valid, rk_rd_data, FIPS_RK10);
    end
    checks++;
    if ({keys_ready, kexp_kld} !== 2'b01) begin
      failures++; $display("FAIL b2b_reload kr/kld=%b exp=01", {keys_ready, kexp_kld});
    end
    wait_ready(n);
    checks++;
    if (n !== 12) begin failures++; $display("FAIL b2b_latency got=%0d exp=12", n); end
    compute_rks(KEY2);
    do_read(4'd10);
    checks++;
    if (rk_rd_data !== KEY2_RK10) begin
      failures++; $display("FAIL b2b_new_rk10 got=%h exp=%h", rk_rd_data, KEY2_RK10);
    end
    do_read(4'd5);
    checks++;
    if (rk_rd_data !== exp_rk[5]) begin
      failures++; $display("FAIL b2b_new_rk5 got=%h exp=%h", rk_rd_data, exp_rk[5]);
    end
  endtask

  task automatic test_flush();
    int n;
    accept_key(FIPS_KEY);
    repeat (6) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if ({busy, keys_ready, key_ready, kexp_kld} !== 4'b0010) begin
      failures++;
      $display("FAIL flush_idle b/kr/kyr/kld=%b exp=0010", {busy, keys_ready, key_ready, kexp_kld});
    end
    key_in = KEY2; key_valid = 1'b1; flush = 1'b1;
    tick();
    key_valid = 1'b0; flush = 1'b0;
    checks++;
    if ({kexp_kld, busy} !== 2'b00) begin
      failures++; $display("FAIL flush_blocks_accept kld/busy=%b exp=00", {kexp_kld, busy});
    end
    do_read(4'd3);
    checks++;
    if ({rk_rd_err, rk_rd_valid} !== 2'b10) begin
      failures++; $display("FAIL flush_unreadable err/valid=%b exp=10", {rk_rd_err, rk_rd_valid});
    end
    compute_rks(FIPS_KEY);
    accept_key(FIPS_KEY);
    wait_ready(n);
    checks++;
    if (n !== 12) begin failures++; $display("FAIL flush_reload_latency got=%0d exp=12", n); end
    do_read(4'd5);
    checks++;
    if (rk_rd_data !== exp_rk[5]) begin
      failures++; $display("FAIL flush_reload_rk5 got=%h exp=%h", rk_rd_data, exp_rk[5]);
    end
    do_read(4'd10);
    checks++;
    if (rk_rd_data !== FIPS_RK10) begin
      failures++; $display("FAIL flush_reload_rk10 got=%h exp=%h", rk_rd_data, FIPS_RK10);
    end
  endtask

  task automatic test_rst_mid_capture();
    int n;
    do_read(4'd10);
    accept_key(KEY2);
    repeat (4) tick();
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({key_ready, kexp_kld, keys_ready, busy, rk_rd_valid, rk_rd_err} !== 6'b100000) begin
      failures++;
      $display("FAIL async_rst_flags got=%b exp=100000",
               {key_ready, kexp_kld, keys_ready, busy, rk_rd_valid, rk_rd_err});
    end
    checks++;
    if (kexp_key !== '0 || rk_rd_data !== '0) begin
      failures++; $display("FAIL async_rst_data kexp_key=%h rd_data=%h exp=0", kexp_key, rk_rd_data);
    end
    tick();
    rst = 1'b0;
    do_read(4'd0);
    checks++;
    if ({rk_rd_err, rk_rd_valid} !== 2'b10 || rk_rd_data !== '0) begin
      failures++; $display("FAIL rst_discard err/valid=%b data=%h", {rk_rd_err, rk_rd_valid}, rk_rd_data);
    end
    compute_rks(KEY2);
    accept_key(KEY2);
    wait_ready(n);
    checks++;
    if (n !== 12) begin failures++; $display("FAIL rst_reload_latency got=%0d exp=12", n); end
    do_read(4'd10);
    checks++;
    if (rk_rd_data !== KEY2_RK10) begin
      failures++; $display("FAIL rst_reload_rk10 got=%h exp=%h", rk_rd_data, KEY2_RK10);
    end
    do_read(4'd0);
    checks++;
    if (rk_rd_data !== KEY2) begin
      failures++; $display("FAIL rst_reload_rk0 got=%h exp=%h", rk_rd_data, KEY2);
    end
  endtask

  task automatic test_held_valid();
    int nacc = 0, nkld = 0, bad = 0, last_acc = -1, last_kld = -1, n;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    key_in = FIPS_KEY;
    key_valid = 1'b1;
    for (int t = 0; t < 20; t++) begin
      if (key_valid && key_ready) begin nacc++; last_acc = t; end
      if (kexp_kld) begin nkld++; last_kld = t; end
      if (key_ready && busy) bad++;
      tick();
    end
    key_valid = 1'b0;
    checks++;
    if (nacc !== 2 || nkld !== 2) begin
      failures++; $display("FAIL held_counts acc=%0d kld=%0d exp=2/2", nacc, nkld);
    end
    checks++;
    if (last_acc !== 13 || last_kld !== 14) begin
      failures++; $display("FAIL held_timing acc_t=%0d kld_t=%0d exp=13/14", last_acc, last_kld);
    end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL held_ready_while_busy got=%0d exp=0", bad); end
    wait_ready(n);
    checks++;
    if (keys_ready !== 1'b1) begin failures++; $display("FAIL held_drain kr=%b exp=1", keys_ready); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read_before_load();
    test_load_fips();
    test_bad_addr();
    test_back_to_back();
    test_flush();
    test_rst_mid_capture();
    test_held_valid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
